pingpong_wr_ctrl: RTL

PINGPONG_WR_CTRL -- requirements
Module: pingpong_wr_ctrl

---
 rtl/pingpong_wr_ctrl_pkg.sv | 17 +
 rtl/pingpong_wr_ctrl_sat_counter.sv | 31 +++
 rtl/pingpong_wr_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pingpong_wr_ctrl_pkg.sv
// rtl/pingpong_wr_ctrl_pkg.sv - shared encodings for the ping-pong frame-buffer write controller
package pingpong_wr_ctrl_pkg;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_WRITING = 2'd1,
      BUF_FULL    = 2'd2,
      BUF_READING = 2'd3
   } buf_state_e;

   typedef enum logic [1:0] {
      WR_IDLE     = 2'd0,
      WR_ISSUE    = 2'd1,
      WR_WAIT_FIN = 2'd2
   } wr_state_e;

endpackage

// File: rtl/pingpong_wr_ctrl_sat_counter.sv
// rtl/pingpong_wr_ctrl_sat_counter.sv - sat_counter: increment-by-one status counter that sticks at all-ones
module pingpong_wr_ctrl_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/pingpong_wr_ctrl.sv
// rtl/pingpong_wr_ctrl.sv - two-buffer write/read arbitration toward camera_adaptor and a consumer
// Optional write-finish watchdog enabled by defining FBUF_WR_TIMEOUT_EN.
module pingpong_wr_ctrl
   import pingpong_wr_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             frame_avail,
   output logic             ddr_write_start,
   output logic             ddr_write_start_valid,
   input  logic             ddr_write_start_ready,
   output logic             odd_even_flag,
   input  logic             ddr_write_finish,
   input  logic             ddr_write_finish_valid,
   output logic             ddr_write_finish_ready,
   output logic             rd_req_valid,
   input  logic             rd_req_ready,
   output logic             rd_buf_sel,
   input  logic             rd_done,
   input  logic             rd_done_sel,
   output logic [3:0]       buf_state,
   output logic             wr_blocked,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   wr_state_e  state_q, state_d;
   buf_state_e buf_q [2];
   buf_state_e buf_d [2];
   logic       wr_sel_q, wr_sel_d;
   logic       rd_sel_q, rd_sel_d;
   logic       pending_q, pending_d;
   logic       odd_even_q, odd_even_d;

   logic issue_go, fin_hs, rd_hs, rd_done_ok, timeout_hit;
   logic drop_inc, err_inc;

   assign issue_go   = (state_q == WR_IDLE) && pending_q && enable && (buf_q[wr_sel_q] == BUF_FREE);
   assign fin_hs     = (state_q == WR_WAIT_FIN) && ddr_write_finish_valid;
   assign rd_hs      = rd_req_valid && rd_req_ready;
   assign rd_done_ok = rd_done && (buf_q[rd_done_sel] == BUF_READING);

`ifdef FBUF_WR_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] tmr_q;

   always_ff @(posedge clk) begin
      if (rst || (state_q != WR_WAIT_FIN)) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_q + TMR_W'(1);
      end
   end

   // A finish arriving on the last watchdog cycle still wins over the timeout.
   assign timeout_hit = (state_q == WR_WAIT_FIN) && !ddr_write_finish_valid &&
                        (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

   pingpong_wr_ctrl_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (timeout_hit),
      .count (timeout_cnt)
   );
`else
   logic unused_tmo;
   assign unused_tmo  = ^TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
   assign timeout_cnt = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WR_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WR_IDLE:     if (issue_go) state_d = WR_ISSUE;
         WR_ISSUE:    if (ddr_write_start_ready) state_d = WR_WAIT_FIN;
         WR_WAIT_FIN: if (fin_hs || timeout_hit) state_d = WR_IDLE;
         default:     state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      ddr_write_start_valid  = (state_q == WR_ISSUE);
      ddr_write_start        = (state_q == WR_ISSUE);
      ddr_write_finish_ready = (state_q == WR_WAIT_FIN);
      odd_even_flag          = odd_even_q;
      wr_blocked             = (state_q == WR_IDLE) && pending_q && (buf_q[wr_sel_q] != BUF_FREE);
   end

   // Each event requires a distinct source state, so at most one touches a given buffer per cycle.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         buf_d[b] = buf_q[b];
      end
      if (issue_go) begin
         buf_d[wr_sel_q] = BUF_WRITING;
      end
      if (fin_hs) begin
         buf_d[wr_sel_q] = ddr_write_finish ? BUF_FULL : BUF_FREE;
      end else if (timeout_hit) begin
         buf_d[wr_sel_q] = BUF_FREE;
      end
      if (rd_hs) begin
         buf_d[rd_sel_q] = BUF_READING;
      end
      if (rd_done_ok) begin
         buf_d[rd_done_sel] = BUF_FREE;
      end
   end

   always_comb begin
      wr_sel_d   = wr_sel_q ^ (fin_hs && ddr_write_finish);
      rd_sel_d   = rd_sel_q ^ rd_hs;
      pending_d  = frame_avail ? 1'b1 : (issue_go ? 1'b0 : pending_q);
      odd_even_d = issue_go ? wr_sel_q : odd_even_q;
      drop_inc   = frame_avail && pending_q && !issue_go;
      err_inc    = (fin_hs && !ddr_write_finish) || (rd_done && !rd_done_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q[0]   <= BUF_FREE;
         buf_q[1]   <= BUF_FREE;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         pending_q  <= 1'b0;
         odd_even_q <= 1'b0;
      end else begin
         buf_q[0]   <= buf_d[0];
         buf_q[1]   <= buf_d[1];
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         pending_q  <= pending_d;
         odd_even_q <= odd_even_d;
      end
   end

   assign rd_req_valid = (buf_q[rd_sel_q] == BUF_FULL);
   assign rd_buf_sel   = rd_sel_q;
   assign buf_state    = {buf_q[1], buf_q[0]};

   pingpong_wr_ctrl_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (drop_inc),
      .count (drop_cnt)
   );

   pingpong_wr_ctrl_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_inc),
      .count (err_cnt)
   );

endmodule
